// File: rtl/drum_pkg.sv
// Shared sizes, state encoding and helpers for the drum step scheduler.
package drum_pkg;
    localparam int STEPS    = 32;
    localparam int SAMPLE_W = 3;
    localparam int MAPS     = 4;
    localparam int STEP_W   = $clog2(STEPS);
    localparam int MAP_W    = $clog2(MAPS);
    localparam int ADDR_W   = MAP_W + STEP_W;

    localparam logic [SAMPLE_W-1:0] SAMPLE_REST = '0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_PLAY,
        ST_DRAIN
    } state_t;

    // Pattern storage is laid out map-major: one contiguous block of steps per map.
    function automatic logic [ADDR_W-1:0] pat_addr(input logic [MAP_W-1:0] map,
                                                   input logic [STEP_W-1:0] step);
        return {map, step};
    endfunction
endpackage

// File: rtl/drum_pattern_ram.sv
// Pattern store: one write port, one registered read port; a same-address
// read and write in one cycle returns the previous contents.
module drum_pattern_ram
    import drum_pkg::*;
(
    input  logic                clk,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [SAMPLE_W-1:0] wr_data,
    input  logic                rd_en,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [SAMPLE_W-1:0] rd_data
);
    logic [SAMPLE_W-1:0] mem [MAPS*STEPS];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end
endmodule

// File: rtl/drum_step_scheduler.sv
// Step sequencer: advances one pattern step per tick, issues non-rest samples
// to the synth over valid/ready and swaps maps only on bar boundaries.
module drum_step_scheduler
    import drum_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    input  logic                tick,
    input  logic [MAP_W-1:0]    map_sel,
    input  logic                map_sel_valid,
    input  logic                wr_en,
    input  logic [MAP_W-1:0]    wr_map,
    input  logic [STEP_W-1:0]   wr_step,
    input  logic [SAMPLE_W-1:0] wr_data,
    output logic                trig_valid,
    input  logic                trig_ready,
    output logic [SAMPLE_W-1:0] trig_sample,
    output logic [STEP_W-1:0]   step_idx,
    output logic [MAP_W-1:0]    active_map,
    output logic                bar_start,
    output logic                overrun,
    output logic                playing
);
    state_t              state_reg;
    logic [STEP_W-1:0]   step_ptr_reg;
    logic [STEP_W-1:0]   step_idx_reg;
    logic [MAP_W-1:0]    active_map_reg;
    logic [MAP_W-1:0]    pending_map_reg;
    logic                pending_flag_reg;
    logic                bar_start_reg;
    logic                playing_reg;
    logic                play_d_reg;
    logic                ovr_arm_reg;
    logic                pend_reg;
    logic [SAMPLE_W-1:0] pend_sample_reg;
    logic [SAMPLE_W-1:0] rd_data;

    logic tick_fire;
    logic wrap;
    logic direct_sel;
    logic new_trig;

    assign tick_fire  = tick && run && (state_reg == ST_ARMED || state_reg == ST_PLAY);
    assign wrap       = tick_fire && (step_ptr_reg == STEP_W'(STEPS - 1));
    assign direct_sel = (state_reg == ST_IDLE) || (state_reg == ST_ARMED);

    drum_pattern_ram u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (pat_addr(wr_map, wr_step)),
        .wr_data (wr_data),
        .rd_en   (tick_fire),
        .rd_addr (pat_addr(active_map_reg, step_ptr_reg)),
        .rd_data (rd_data)
    );

    // The RAM output register holds the freshly played code in the cycle after
    // a tick; a non-rest code there takes precedence over any held trigger.
    assign new_trig    = play_d_reg && (rd_data != SAMPLE_REST);
    assign trig_valid  = pend_reg || new_trig;
    assign trig_sample = new_trig ? rd_data : pend_sample_reg;
    assign overrun     = new_trig && ovr_arm_reg;

    assign step_idx   = step_idx_reg;
    assign active_map = active_map_reg;
    assign bar_start  = bar_start_reg;
    assign playing    = playing_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            playing_reg  <= 1'b0;
            step_ptr_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    step_ptr_reg <= '0;
                    if (run) begin
                        state_reg   <= ST_ARMED;
                        playing_reg <= 1'b1;
                    end
                end
                ST_ARMED: begin
                    if (!run) begin
                        state_reg    <= ST_IDLE;
                        playing_reg  <= 1'b0;
                        step_ptr_reg <= '0;
                    end else if (tick) begin
                        state_reg    <= ST_PLAY;
                        step_ptr_reg <= step_ptr_reg + STEP_W'(1);
                    end
                end
                ST_PLAY: begin
                    if (!run) begin
                        step_ptr_reg <= '0;
                        if (trig_valid) begin
                            state_reg <= ST_DRAIN;
                        end else begin
                            state_reg   <= ST_IDLE;
                            playing_reg <= 1'b0;
                        end
                    end else if (tick) begin
                        step_ptr_reg <= step_ptr_reg + STEP_W'(1);
                    end
                end
                ST_DRAIN: begin
                    // Also leave if the trigger was already taken on the way in.
                    if (trig_ready || !trig_valid) begin
                        state_reg    <= ST_IDLE;
                        playing_reg  <= 1'b0;
                        step_ptr_reg <= '0;
                    end
                end
                default: begin
                    state_reg   <= ST_IDLE;
                    playing_reg <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            step_idx_reg    <= '0;
            bar_start_reg   <= 1'b0;
            play_d_reg      <= 1'b0;
            ovr_arm_reg     <= 1'b0;
            pend_reg        <= 1'b0;
            pend_sample_reg <= '0;
        end else begin
            play_d_reg    <= tick_fire;
            bar_start_reg <= tick_fire && (step_ptr_reg == '0);
            ovr_arm_reg   <= tick_fire && trig_valid && !trig_ready;
            pend_reg      <= trig_valid && !trig_ready;
            if (tick_fire) begin
                step_idx_reg <= step_ptr_reg;
            end
            if (trig_valid) begin
                pend_sample_reg <= trig_sample;
            end
        end
    end

    // While stopped or armed a request lands at once; while playing it waits
    // for the wrap so the whole next bar comes from the new map.
    always_ff @(posedge clk) begin
        if (rst) begin
            active_map_reg   <= '0;
            pending_map_reg  <= '0;
            pending_flag_reg <= 1'b0;
        end else if (map_sel_valid) begin
            pending_map_reg <= map_sel;
            if (direct_sel || wrap) begin
                active_map_reg   <= map_sel;
                pending_flag_reg <= 1'b0;
            end else begin
                pending_flag_reg <= 1'b1;
            end
        end else if (pending_flag_reg && (direct_sel || wrap)) begin
            active_map_reg   <= pending_map_reg;
            pending_flag_reg <= 1'b0;
        end
    end
endmodule

// File: tb/tb_drum_step_scheduler.sv
// Scoreboard bench for drum_step_scheduler: stimulus queues expected triggers,
// bar starts and overruns; a negedge monitor pops and compares them.
module tb_drum_step_scheduler;
    import drum_pkg::*;

    logic                clk = 1'b0;
    logic                rst;
    logic                run;
    logic                tick;
    logic [MAP_W-1:0]    map_sel;
    logic                map_sel_valid;
    logic                wr_en;
    logic [MAP_W-1:0]    wr_map;
    logic [STEP_W-1:0]   wr_step;
    logic [SAMPLE_W-1:0] wr_data;
    logic                trig_valid;
    logic                trig_ready;
    logic [SAMPLE_W-1:0] trig_sample;
    logic [STEP_W-1:0]   step_idx;
    logic [MAP_W-1:0]    active_map;
    logic                bar_start;
    logic                overrun;
    logic                playing;

    drum_step_scheduler dut (
        .clk           (clk),
        .rst           (rst),
        .run           (run),
        .tick          (tick),
        .map_sel       (map_sel),
        .map_sel_valid (map_sel_valid),
        .wr_en         (wr_en),
        .wr_map        (wr_map),
        .wr_step       (wr_step),
        .wr_data       (wr_data),
        .trig_valid    (trig_valid),
        .trig_ready    (trig_ready),
        .trig_sample   (trig_sample),
        .step_idx      (step_idx),
        .active_map    (active_map),
        .bar_start     (bar_start),
        .overrun       (overrun),
        .playing       (playing)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_trig_q[$];
    int exp_bar_q[$];
    int exp_ovr_q[$];
    int model_mem [MAPS][STEPS];

    task automatic chk(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (trig_valid && trig_ready) begin
                $display("trigger accepted: sample=%0d step=%0d map=%0d", trig_sample, step_idx, active_map);
                if (exp_trig_q.size() == 0) chk("unexpected_trigger", int'(trig_sample), -1);
                else chk("trig_sample_accepted", int'(trig_sample), exp_trig_q.pop_front());
            end
            if (bar_start) begin
                $display("bar start: map=%0d step=%0d", active_map, step_idx);
                chk("bar_step", int'(step_idx), 0);
                if (exp_bar_q.size() == 0) chk("unexpected_bar_start", int'(active_map), -1);
                else chk("bar_map", int'(active_map), exp_bar_q.pop_front());
            end
            if (overrun) begin
                $display("overrun: step=%0d sample=%0d", step_idx, trig_sample);
                if (exp_ovr_q.size() == 0) chk("unexpected_overrun", int'(step_idx), -1);
                else chk("overrun_step", int'(step_idx), exp_ovr_q.pop_front());
            end
        end
    end

    task automatic step_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_once();
        tick = 1'b1;
        step_cyc();
        tick = 1'b0;
    endtask

    task automatic wr(input int m, input int s, input int d);
        wr_en   = 1'b1;
        wr_map  = MAP_W'(m);
        wr_step = STEP_W'(s);
        wr_data = SAMPLE_W'(d);
        step_cyc();
        wr_en = 1'b0;
        model_mem[m][s] = d;
    endtask

    // One tick with trig_ready high; expects step s of map m to be played.
    task automatic play_tick(input int s, input int m);
        int code;
        code = model_mem[m][s];
        if (code != 0) exp_trig_q.push_back(code);
        if (s == 0) exp_bar_q.push_back(m);
        tick_once();
        chk("step_idx", int'(step_idx), s);
        chk("bar_start", int'(bar_start), int'(s == 0));
        chk("trig_valid", int'(trig_valid), int'(code != 0));
        if (code != 0) chk("trig_sample", int'(trig_sample), code);
        step_cyc();
        step_cyc();
    endtask

    task automatic stop_play();
        run = 1'b0;
        step_cyc();
        step_cyc();
    endtask

    task automatic chk_reset_outputs();
        chk("rst_trig_valid", int'(trig_valid), 0);
        chk("rst_trig_sample", int'(trig_sample), 0);
        chk("rst_step_idx", int'(step_idx), 0);
        chk("rst_active_map", int'(active_map), 0);
        chk("rst_bar_start", int'(bar_start), 0);
        chk("rst_overrun", int'(overrun), 0);
        chk("rst_playing", int'(playing), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; run = 1'b0; tick = 1'b0; map_sel = '0; map_sel_valid = 1'b0;
        wr_en = 1'b0; wr_map = '0; wr_step = '0; wr_data = '0; trig_ready = 1'b0;
        repeat (3) step_cyc();
        rst = 1'b0;
        chk_reset_outputs();

        // Playback with ready tied high, ticks every 20 cycles
        trig_ready = 1'b1;
        for (int s = 0; s < STEPS; s++) wr(0, s, 0);
        wr(0, 0, 3);
        wr(0, 2, 5);
        run = 1'b1;
        step_cyc();
        chk("armed_playing", int'(playing), 1);
        for (int s = 0; s < 3; s++) begin
            play_tick(s, 0);
            repeat (17) step_cyc();
        end

        // Backpressure and overrun
        stop_play();
        chk("stopped_playing", int'(playing), 0);
        wr(0, 0, 2);
        wr(0, 1, 4);
        trig_ready = 1'b0;
        run = 1'b1;
        step_cyc();
        exp_bar_q.push_back(0);
        tick_once();
        chk("bp_valid", int'(trig_valid), 1);
        chk("bp_sample", int'(trig_sample), 2);
        chk("bp_no_overrun", int'(overrun), 0);
        repeat (3) step_cyc();
        chk("bp_hold_valid", int'(trig_valid), 1);
        chk("bp_hold_sample", int'(trig_sample), 2);
        exp_ovr_q.push_back(1);
        tick_once();
        chk("ovr_sample", int'(trig_sample), 4);
        chk("ovr_pulse", int'(overrun), 1);
        chk("ovr_step", int'(step_idx), 1);
        step_cyc();
        chk("ovr_one_cycle", int'(overrun), 0);
        chk("ovr_hold_sample", int'(trig_sample), 4);
        exp_trig_q.push_back(4);
        trig_ready = 1'b1;
        step_cyc();
        trig_ready = 1'b0;
        chk("accept_drops_valid", int'(trig_valid), 0);

        // Write collision: tick reads step 5 (old 2) while 7 is written there
        stop_play();
        wr(0, 5, 2);
        trig_ready = 1'b1;
        run = 1'b1;
        step_cyc();
        for (int s = 0; s < 5; s++) play_tick(s, 0);
        wr_en = 1'b1; wr_map = '0; wr_step = STEP_W'(5); wr_data = SAMPLE_W'(7);
        exp_trig_q.push_back(2);
        tick = 1'b1;
        step_cyc();
        tick = 1'b0;
        wr_en = 1'b0;
        model_mem[0][5] = 7;
        chk("collision_old_data", int'(trig_sample), 2);
        chk("collision_step", int'(step_idx), 5);
        step_cyc();
        step_cyc();
        for (int s = 6; s < STEPS; s++) play_tick(s, 0);
        for (int s = 0; s < 6; s++) play_tick(s, 0);

        // Map switch requested mid-bar applies at the next step 0
        stop_play();
        for (int s = 0; s < STEPS; s++) begin
            wr(0, s, 1);
            wr(1, s, 6);
        end
        run = 1'b1;
        step_cyc();
        for (int s = 0; s <= 10; s++) play_tick(s, 0);
        map_sel = MAP_W'(1);
        map_sel_valid = 1'b1;
        step_cyc();
        map_sel_valid = 1'b0;
        chk("map_pending_hold", int'(active_map), 0);
        for (int s = 11; s < STEPS; s++) play_tick(s, 0);
        play_tick(0, 1);
        chk("map_switched", int'(active_map), 1);

        // Stop with a pending trigger: drain, ignore ticks, then restart at step 0
        trig_ready = 1'b0;
        tick_once();
        chk("drain_pending_valid", int'(trig_valid), 1);
        chk("drain_pending_sample", int'(trig_sample), 6);
        run = 1'b0;
        step_cyc();
        chk("drain_playing", int'(playing), 1);
        for (int i = 0; i < 3; i++) begin
            tick_once();
            chk("drain_hold_sample", int'(trig_sample), 6);
            chk("drain_hold_step", int'(step_idx), 1);
            chk("drain_no_overrun", int'(overrun), 0);
        end
        exp_trig_q.push_back(6);
        trig_ready = 1'b1;
        step_cyc();
        chk("drain_done_playing", int'(playing), 0);
        chk("drain_done_valid", int'(trig_valid), 0);
        run = 1'b1;
        step_cyc();
        play_tick(0, 1);

        // Synchronous reset while a trigger is pending
        trig_ready = 1'b0;
        tick_once();
        chk("pre_reset_valid", int'(trig_valid), 1);
        run = 1'b0;
        rst = 1'b1;
        step_cyc();
        rst = 1'b0;
        chk_reset_outputs();
        map_sel = MAP_W'(1);
        map_sel_valid = 1'b1;
        step_cyc();
        map_sel_valid = 1'b0;
        chk("idle_direct_map", int'(active_map), 1);
        trig_ready = 1'b1;
        run = 1'b1;
        step_cyc();
        play_tick(0, 1);
        play_tick(1, 1);

        repeat (4) step_cyc();
        chk("trig_queue_empty", exp_trig_q.size(), 0);
        chk("bar_queue_empty", exp_bar_q.size(), 0);
        chk("ovr_queue_empty", exp_ovr_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
